// File: rtl/ifu_prefetch_q_if.sv
// Fetch-unit bus: ICCM read port plus the instruction handshake towards dec.
// master = fetch unit, slave = ICCM/dec side.
interface ifu_prefetch_q_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] iccm_rd_addr;
    logic            iccm_rd_en;
    logic [31:0]     iccm_rd_data;
    logic            instr_valid_o;
    logic [31:0]     instr_o;
    logic [XLEN-1:0] instr_addr_o;
    logic            dec_ready_i;

    modport master (
        output iccm_rd_addr,
        output iccm_rd_en,
        input  iccm_rd_data,
        output instr_valid_o,
        output instr_o,
        output instr_addr_o,
        input  dec_ready_i
    );

    modport slave (
        input  iccm_rd_addr,
        input  iccm_rd_en,
        output iccm_rd_data,
        input  instr_valid_o,
        input  instr_o,
        input  instr_addr_o,
        output dec_ready_i
    );
endinterface

// File: rtl/ifu_prefetch_q.sv
// Instruction fetch unit with a prefetch queue between the ICCM and dec.
// Sequential fetch, one-cycle ICCM latency, flush redirect kills queued/in-flight reads.
module ifu_prefetch_q #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h13,
    localparam int             PW        = $clog2(DEPTH),
    localparam int             CW        = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    ifu_prefetch_q_if.master bus,
    input  logic            flush_from_exe,
    input  logic [XLEN-1:0] flush_addr_exe,
    input  logic            flush_from_dec,
    input  logic [XLEN-1:0] flush_addr_dec,
    output logic [CW-1:0]   q_count_o
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            infl_q, infl_d;
    logic [XLEN-1:0] infl_pc_q, infl_pc_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic [31:0]     mem_data [DEPTH];
    logic [XLEN-1:0] mem_pc   [DEPTH];

    logic            flush_any;
    logic [XLEN-1:0] flush_tgt;
    logic            head_vld;
    logic            pop;
    logic            push;
    logic            issue;
    logic [CW:0]     occ;

    always_comb begin
        flush_any = flush_from_exe | flush_from_dec;
        flush_tgt = flush_from_exe ? flush_addr_exe : flush_addr_dec;
        flush_tgt[1:0] = 2'b00;
        head_vld  = (count_q != '0);
        pop       = head_vld && bus.dec_ready_i && !flush_any;
        // data returning in a flush cycle belongs to a killed read
        push      = infl_q && !flush_any;
        // the in-flight read already owns a slot; a pop frees one this cycle
        occ       = {1'b0, count_q} + (CW + 1)'(infl_q) - (CW + 1)'(pop);
        issue     = rst_n && !flush_any && (occ < (CW + 1)'(DEPTH));
    end

    always_comb begin
        pc_d      = pc_q;
        infl_d    = issue;
        infl_pc_d = infl_pc_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (flush_any) begin
            pc_d    = flush_tgt;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (issue) begin
                pc_d      = pc_q + XLEN'(4);
                infl_pc_d = pc_q;
            end
            if (pop) head_d = head_q + PW'(1);
            if (push) tail_d = tail_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            pc_q      <= pc_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[tail_q] <= bus.iccm_rd_data;
            mem_pc[tail_q]   <= infl_pc_q;
        end
    end

    always_comb begin
        bus.iccm_rd_en    = issue;
        bus.iccm_rd_addr  = pc_q;
        bus.instr_valid_o = head_vld;
        bus.instr_o       = head_vld ? mem_data[head_q] : NOP_INSTR;
        bus.instr_addr_o  = head_vld ? mem_pc[head_q] : '0;
        q_count_o         = count_q;
    end

endmodule
